// File: rtl/ma_stage_hs.sv
// Memory-access pipeline stage with a req/gnt/rvalid bus handshake, byte-lane
// steering, misalignment and timeout detection, and a registered WB boundary.
module ma_stage_hs #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mem_wren,
  input  logic            i_mem_rden,
  input  logic            i_rd_wren,
  input  logic            i_insn_vld,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_wb_sel,
  input  logic [4:0]      i_rd_addr,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_stall,
  output logic            o_bus_req,
  output logic            o_bus_we,
  output logic [XLEN-1:0] o_bus_addr,
  output logic [XLEN-1:0] o_bus_wdata,
  output logic [XLEN/8-1:0] o_bus_be,
  input  logic            i_bus_gnt,
  input  logic            i_bus_rvalid,
  input  logic [XLEN-1:0] i_bus_rdata,
  output logic [1:0]      o_wb_wb_sel,
  output logic            o_wb_rd_wren,
  output logic            o_wb_insn_vld,
  output logic [4:0]      o_wb_rd_addr,
  output logic [XLEN-1:0] o_wb_alu_data,
  output logic [XLEN-1:0] o_wb_ld_data,
  output logic [XLEN-1:0] o_wb_pc,
  output logic            o_wb_misalign,
  output logic            o_wb_bus_err
);

  localparam int BEW = XLEN / 8;
  localparam int OFF = $clog2(BEW);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            access, is_load, misalign, cnt_hit;
  logic            bus_req, done, bus_err, pending, stall, load_ok;
  logic [1:0]      sz;
  logic [OFF-1:0]  offset;
  logic [BEW-1:0]  be_mask;
  logic [63:0]     sh64, ext64;
  logic [XLEN-1:0] ld_ext;

  assign access  = i_insn_vld && (i_mem_wren || i_mem_rden);
  assign is_load = i_mem_rden;
  assign offset  = i_alu_data[OFF-1:0];
  // Doubleword encodings collapse to word accesses on a 32-bit datapath.
  assign sz      = (XLEN == 32 && i_funct3[1:0] == 2'b11) ? 2'b10 : i_funct3[1:0];
  assign cnt_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    misalign = 1'b0;
    be_mask  = '1;
    o_bus_wdata = i_rs2_data;
    unique case (sz)
      2'b00: begin be_mask = BEW'(1);  o_bus_wdata = {BEW{i_rs2_data[7:0]}}; end
      2'b01: begin be_mask = BEW'(3);  misalign = i_alu_data[0];
                   o_bus_wdata = {(BEW/2){i_rs2_data[15:0]}}; end
      2'b10: begin be_mask = BEW'(15); misalign = |i_alu_data[1:0];
                   o_bus_wdata = {(BEW/4){i_rs2_data[31:0]}}; end
      default: misalign = |i_alu_data[2:0];
    endcase
  end

  assign o_bus_be   = be_mask << offset;
  assign o_bus_addr = i_alu_data & ~XLEN'(BEW - 1);

  // Width-independent extension: build at 64 bits, then truncate to XLEN.
  always_comb begin
    sh64 = 64'(i_bus_rdata >> {offset, 3'b000});
    unique case (i_funct3)
      3'b000:  ext64 = {{56{sh64[7]}},  sh64[7:0]};
      3'b001:  ext64 = {{48{sh64[15]}}, sh64[15:0]};
      3'b010:  ext64 = {{32{sh64[31]}}, sh64[31:0]};
      3'b100:  ext64 = {56'd0, sh64[7:0]};
      3'b101:  ext64 = {48'd0, sh64[15:0]};
      3'b110:  ext64 = (XLEN == 32) ? {{32{sh64[31]}}, sh64[31:0]} : {32'd0, sh64[31:0]};
      default: ext64 = sh64;
    endcase
  end
  assign ld_ext = ext64[XLEN-1:0];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bus_req = 1'b0;
    done    = 1'b0;
    bus_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (misalign) begin
            done = 1'b1;
          end else begin
            bus_req = 1'b1;
            if (!i_bus_gnt)   state_d = WAIT_GNT;
            else if (is_load) state_d = WAIT_RSP;
            else              done    = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        if (cnt_hit) begin
          done = 1'b1; bus_err = 1'b1; state_d = IDLE;
        end else begin
          bus_req = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (i_bus_gnt) begin
            if (is_load) state_d = WAIT_RSP;
            else begin done = 1'b1; state_d = IDLE; cnt_d = '0; end
          end
        end
      end
      WAIT_RSP: begin
        if (i_bus_rvalid) begin
          done = 1'b1; state_d = IDLE;
        end else if (cnt_hit) begin
          done = 1'b1; bus_err = 1'b1; state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending   = access || (state_q != IDLE);
  assign stall     = pending && !done && !i_rst;
  assign o_stall   = stall;
  assign o_bus_req = bus_req && !i_rst;
  assign o_bus_we  = o_bus_req && !is_load;
  assign load_ok   = access && is_load && !misalign && !bus_err;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_wb_sel   <= '0;
      o_wb_rd_wren  <= 1'b0;
      o_wb_insn_vld <= 1'b0;
      o_wb_rd_addr  <= '0;
      o_wb_alu_data <= '0;
      o_wb_ld_data  <= '0;
      o_wb_pc       <= '0;
      o_wb_misalign <= 1'b0;
      o_wb_bus_err  <= 1'b0;
    end else if (stall) begin
      o_wb_insn_vld <= 1'b0;
      o_wb_rd_wren  <= 1'b0;
      o_wb_misalign <= 1'b0;
      o_wb_bus_err  <= 1'b0;
    end else begin
      o_wb_wb_sel   <= i_wb_sel;
      o_wb_rd_wren  <= i_rd_wren && !(access && (misalign || bus_err));
      o_wb_insn_vld <= i_insn_vld;
      o_wb_rd_addr  <= i_rd_addr;
      o_wb_alu_data <= i_alu_data;
      o_wb_ld_data  <= load_ok ? ld_ext : '0;
      o_wb_pc       <= i_pc;
      o_wb_misalign <= access && misalign;
      o_wb_bus_err  <= bus_err;
    end
  end

endmodule

// File: tb/tb_ma_stage_hs.sv
// Directed bench for ma_stage_hs: handshake timing, lane steering, extension,
// misalignment, timeout abort and reset during an outstanding load.
module tb_ma_stage_hs;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_mem_wren, i_mem_rden, i_rd_wren, i_insn_vld;
  logic [2:0]  i_funct3;
  logic [1:0]  i_wb_sel;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_alu_data, i_rs2_data, i_pc;
  logic        o_stall, o_bus_req, o_bus_we;
  logic [31:0] o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_gnt, i_bus_rvalid;
  logic [31:0] i_bus_rdata;
  logic [1:0]  o_wb_wb_sel;
  logic        o_wb_rd_wren, o_wb_insn_vld;
  logic [4:0]  o_wb_rd_addr;
  logic [31:0] o_wb_alu_data, o_wb_ld_data, o_wb_pc;
  logic        o_wb_misalign, o_wb_bus_err;

  int checks = 0;
  int failures = 0;

  ma_stage_hs #(.XLEN(32), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_mem_wren(i_mem_wren), .i_mem_rden(i_mem_rden), .i_rd_wren(i_rd_wren),
    .i_insn_vld(i_insn_vld), .i_funct3(i_funct3), .i_wb_sel(i_wb_sel),
    .i_rd_addr(i_rd_addr), .i_alu_data(i_alu_data), .i_rs2_data(i_rs2_data),
    .i_pc(i_pc), .o_stall(o_stall), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
    .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
    .o_wb_wb_sel(o_wb_wb_sel), .o_wb_rd_wren(o_wb_rd_wren),
    .o_wb_insn_vld(o_wb_insn_vld), .o_wb_rd_addr(o_wb_rd_addr),
    .o_wb_alu_data(o_wb_alu_data), .o_wb_ld_data(o_wb_ld_data), .o_wb_pc(o_wb_pc),
    .o_wb_misalign(o_wb_misalign), .o_wb_bus_err(o_wb_bus_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_mem_wren = 0; i_mem_rden = 0; i_rd_wren = 0; i_insn_vld = 0;
    i_funct3 = 3'b000; i_wb_sel = 2'b00; i_rd_addr = 5'd0;
    i_alu_data = 32'd0; i_rs2_data = 32'd0; i_pc = 32'd0;
    i_bus_gnt = 0; i_bus_rvalid = 0; i_bus_rdata = 32'd0;
  endtask

  task automatic drive_mem(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2);
    i_insn_vld = 1; i_mem_rden = rd; i_mem_wren = wr; i_rd_wren = rd;
    i_funct3 = f3; i_alu_data = addr; i_rs2_data = rs2;
    i_rd_addr = 5'd5; i_wb_sel = 2'b01; i_pc = 32'h0000_1000;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst = 1;
    tick(); tick();
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", o_stall); end
    checks++; if (o_bus_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", o_bus_req); end
    checks++; if (o_wb_insn_vld !== 1'b0 || o_wb_rd_wren !== 1'b0) begin failures++; $display("FAIL reset_wb_ctl got=%0h%0h exp=00", o_wb_insn_vld, o_wb_rd_wren); end
    checks++; if (o_wb_ld_data !== 32'd0 || o_wb_pc !== 32'd0) begin failures++; $display("FAIL reset_wb_data got=%h/%h exp=0/0", o_wb_ld_data, o_wb_pc); end
    i_rst = 0;
  endtask

  task automatic test_lw_zero_wait();
    drive_mem(1, 0, 3'b010, 32'h104, 32'd0);
    i_bus_gnt = 1;
    #1;
    checks++; if (o_stall !== 1'b1) begin failures++; $display("FAIL lw_stall1 got=%0h exp=1", o_stall); end
    checks++; if (o_bus_req !== 1'b1 || o_bus_we !== 1'b0) begin failures++; $display("FAIL lw_req got=%0h we=%0h exp=1/0", o_bus_req, o_bus_we); end
    checks++; if (o_bus_be !== 4'b1111) begin failures++; $display("FAIL lw_be got=%b exp=1111", o_bus_be); end
    checks++; if (o_bus_addr !== 32'h104) begin failures++; $display("FAIL lw_addr got=%h exp=00000104", o_bus_addr); end
    tick();
    checks++; if (o_wb_insn_vld !== 1'b0) begin failures++; $display("FAIL lw_bubble got=%0h exp=0", o_wb_insn_vld); end
    i_bus_gnt = 0; i_bus_rvalid = 1; i_bus_rdata = 32'h8000_00F0;
    #1;
    checks++; if (o_stall !== 1'b0 || o_bus_req !== 1'b0) begin failures++; $display("FAIL lw_rsp_cycle got=%0h%0h exp=00", o_stall, o_bus_req); end
    tick();
    checks++; if (o_wb_ld_data !== 32'h8000_00F0) begin failures++; $display("FAIL lw_data got=%h exp=800000f0", o_wb_ld_data); end
    checks++; if (o_wb_rd_wren !== 1'b1 || o_wb_insn_vld !== 1'b1 || o_wb_rd_addr !== 5'd5) begin failures++; $display("FAIL lw_wb_ctl got=%0h%0h%0d exp=1 1 5", o_wb_rd_wren, o_wb_insn_vld, o_wb_rd_addr); end
    clear_inputs();
  endtask

  task automatic test_byte_loads();
    logic [31:0] exp_data [2];
    logic [2:0]  f3s [2];
    exp_data[0] = 32'hFFFF_FF80; exp_data[1] = 32'h0000_0080;
    f3s[0] = 3'b000; f3s[1] = 3'b100;
    for (int k = 0; k < 2; k++) begin
      drive_mem(1, 0, f3s[k], 32'h103, 32'd0);
      i_bus_gnt = 1;
      #1;
      checks++; if (o_bus_be !== 4'b1000) begin failures++; $display("FAIL lb_be[%0d] got=%b exp=1000", k, o_bus_be); end
      tick();
      i_bus_gnt = 0; i_bus_rvalid = 1; i_bus_rdata = 32'h8012_3456;
      tick();
      checks++; if (o_wb_ld_data !== exp_data[k]) begin failures++; $display("FAIL lb_data[%0d] got=%h exp=%h", k, o_wb_ld_data, exp_data[k]); end
      clear_inputs();
    end
  endtask

  task automatic test_sh_delayed_gnt();
    drive_mem(0, 1, 3'b001, 32'h102, 32'h1234_ABCD);
    for (int i = 0; i < 4; i++) begin
      i_bus_gnt = (i == 3);
      #1;
      checks++; if (o_bus_req !== 1'b1 || o_bus_we !== 1'b1) begin failures++; $display("FAIL sh_req[%0d] got=%0h we=%0h exp=1/1", i, o_bus_req, o_bus_we); end
      checks++; if (o_bus_be !== 4'b1100 || o_bus_wdata !== 32'hABCD_ABCD || o_bus_addr !== 32'h100) begin failures++; $display("FAIL sh_bus[%0d] got=%b %h %h exp=1100 abcdabcd 00000100", i, o_bus_be, o_bus_wdata, o_bus_addr); end
      checks++; if (o_stall !== (i != 3)) begin failures++; $display("FAIL sh_stall[%0d] got=%0h exp=%0h", i, o_stall, (i != 3)); end
      tick();
    end
    clear_inputs();
    #1;
    checks++; if (o_bus_req !== 1'b0) begin failures++; $display("FAIL sh_req_after got=%0h exp=0", o_bus_req); end
    checks++; if (o_wb_insn_vld !== 1'b1 || o_wb_misalign !== 1'b0 || o_wb_bus_err !== 1'b0) begin failures++; $display("FAIL sh_wb got=%0h%0h%0h exp=100", o_wb_insn_vld, o_wb_misalign, o_wb_bus_err); end
  endtask

  task automatic test_misalign();
    drive_mem(1, 0, 3'b010, 32'h106, 32'd0);
    #1;
    checks++; if (o_bus_req !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL mis_req_stall got=%0h%0h exp=00", o_bus_req, o_stall); end
    tick();
    checks++; if (o_wb_misalign !== 1'b1 || o_wb_rd_wren !== 1'b0 || o_wb_insn_vld !== 1'b1) begin failures++; $display("FAIL mis_wb got=%0h%0h%0h exp=101", o_wb_misalign, o_wb_rd_wren, o_wb_insn_vld); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    drive_mem(1, 0, 3'b010, 32'h200, 32'd0);
    i_bus_gnt = 1;
    tick();
    i_bus_gnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (o_stall !== (i != 3) || o_bus_req !== 1'b0) begin failures++; $display("FAIL to_wait[%0d] got=%0h%0h exp=%0h0", i, o_stall, o_bus_req, (i != 3)); end
      tick();
    end
    checks++; if (o_wb_bus_err !== 1'b1 || o_wb_rd_wren !== 1'b0 || o_wb_insn_vld !== 1'b1) begin failures++; $display("FAIL to_wb got=%0h%0h%0h exp=101", o_wb_bus_err, o_wb_rd_wren, o_wb_insn_vld); end
    drive_mem(1, 0, 3'b010, 32'h204, 32'd0);
    i_bus_gnt = 1;
    tick();
    i_bus_gnt = 0; i_bus_rvalid = 1; i_bus_rdata = 32'h1122_3344;
    tick();
    checks++; if (o_wb_ld_data !== 32'h1122_3344 || o_wb_bus_err !== 1'b0 || o_wb_rd_wren !== 1'b1) begin failures++; $display("FAIL to_recover got=%h %0h %0h exp=11223344 0 1", o_wb_ld_data, o_wb_bus_err, o_wb_rd_wren); end
    clear_inputs();
  endtask

  task automatic test_passthrough_and_stray();
    i_insn_vld = 1; i_rd_wren = 1; i_alu_data = 32'hDEAD_BEEF; i_pc = 32'h40;
    i_wb_sel = 2'b10; i_rd_addr = 5'd9; i_bus_gnt = 1; i_bus_rvalid = 1;
    #1;
    checks++; if (o_stall !== 1'b0 || o_bus_req !== 1'b0) begin failures++; $display("FAIL pass_stall got=%0h%0h exp=00", o_stall, o_bus_req); end
    tick();
    checks++; if (o_wb_alu_data !== 32'hDEAD_BEEF || o_wb_pc !== 32'h40 || o_wb_wb_sel !== 2'b10) begin failures++; $display("FAIL pass_data got=%h %h %0d exp=deadbeef 00000040 2", o_wb_alu_data, o_wb_pc, o_wb_wb_sel); end
    checks++; if (o_wb_rd_wren !== 1'b1 || o_wb_rd_addr !== 5'd9 || o_wb_misalign !== 1'b0) begin failures++; $display("FAIL pass_ctl got=%0h %0d %0h exp=1 9 0", o_wb_rd_wren, o_wb_rd_addr, o_wb_misalign); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_access();
    drive_mem(1, 0, 3'b010, 32'h300, 32'd0);
    i_bus_gnt = 1;
    tick();
    clear_inputs();
    i_rst = 1;
    #1;
    checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%0h exp=0", o_stall); end
    tick();
    i_rst = 0;
    i_bus_rvalid = 1; i_bus_rdata = 32'hFFFF_FFFF;
    #1;
    checks++; if (o_stall !== 1'b0 || o_bus_req !== 1'b0) begin failures++; $display("FAIL rst_late_rv got=%0h%0h exp=00", o_stall, o_bus_req); end
    tick();
    checks++; if (o_wb_insn_vld !== 1'b0 || o_wb_rd_wren !== 1'b0 || o_wb_ld_data !== 32'd0) begin failures++; $display("FAIL rst_no_wb got=%0h%0h %h exp=00 00000000", o_wb_insn_vld, o_wb_rd_wren, o_wb_ld_data); end
    clear_inputs();
  endtask

  initial begin
    i_rst = 1;
    clear_inputs();
    test_reset();
    test_lw_zero_wait();
    test_byte_loads();
    test_sh_delayed_gnt();
    test_misalign();
    test_timeout();
    test_passthrough_and_stray();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
